// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared CPU memory-bus opcodes, responder state encoding and latency bounds
package mem_bus_pkg;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_SWEEP} mem_state_t;
endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port array with synchronous write and combinational read
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // write port; contents are never reset here
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: req/ack memory responder with programmable read latency; MEM_SWEEP_EN adds a zeroing sweep after reset
module mem_responder import mem_bus_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              operation,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0] memory_input,
  output logic [DATA_W-1:0] memory_value,
  output logic              ack,
  output logic              busy
);
  mem_state_t state_q, state_d;
  logic [2:0] cnt_q;
  logic op_q;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [DATA_W-1:0] value_q, ram_wdata, ram_rdata;
  logic ram_we, accept, load_value, sweep_pend;
`ifdef MEM_SWEEP_EN
  logic [ADDR_W-1:0] sweep_q;
  // a pending sweep is armed by reset and consumed on the first edge out of reset
  always_ff @(posedge clk)
    if (!reset) begin
      sweep_pend <= 1'b1;
      sweep_q <= '0;
    end else begin
      if (state_q == ST_IDLE) sweep_pend <= 1'b0;
      sweep_q <= state_q == ST_SWEEP ? sweep_q + 1'b1 : '0;
    end
`else
  assign sweep_pend = 1'b0;
`endif
  assign accept = state_q == ST_IDLE && req && !sweep_pend;
  assign load_value = (accept && operation == OP_READ && READ_LATENCY == 1) ||
                      (state_q == ST_WAIT && cnt_q == 3'd1 && op_q == OP_READ);
  // next state and array port steering; writes land on the accepting edge
  always_comb begin
    state_d = state_q;
    ram_we = 1'b0;
    ram_addr = state_q == ST_IDLE ? memory_address : addr_q;
    ram_wdata = memory_input;
    case (state_q)
      ST_IDLE: begin
        if (sweep_pend) state_d = ST_SWEEP;
        else if (req) begin
          ram_we = operation == OP_WRITE;
          state_d = (operation == OP_WRITE || READ_LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: state_d = cnt_q == 3'd1 ? ST_RESP : ST_WAIT;
      ST_RESP: state_d = ST_IDLE;
`ifdef MEM_SWEEP_EN
      ST_SWEEP: begin
        ram_we = 1'b1;
        ram_addr = sweep_q;
        ram_wdata = '0;
        state_d = &sweep_q ? ST_IDLE : ST_SWEEP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end
  // state, latency counter, request latches and the held read value
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      op_q <= OP_READ;
      addr_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= accept ? 3'(READ_LATENCY - 1) : state_q == ST_WAIT ? cnt_q - 3'd1 : cnt_q;
      if (accept) begin
        op_q <= operation;
        addr_q <= memory_address;
      end
      if (load_value) value_q <= ram_rdata;
    end
  sp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk  (clk),
    .we   (ram_we && reset),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  assign memory_value = value_q;
  assign ack = state_q == ST_RESP;
  assign busy = state_q != ST_IDLE;
endmodule
